// File: rtl/uart_tx_bridge_pkg.sv
// Shared definitions for the UART transmit bridge: register offsets,
// STATUS bit positions, transmitter state encoding and a STATUS packer.
package uart_tx_bridge_pkg;

  // Register word offsets (addr = CPU address bits [3:2])
  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_BUSY   = 2;
  localparam int STAT_IRQ_EN = 3;
  localparam int STAT_OVF    = 4;

  // Serial frame shape: start + 8 data + stop
  localparam int DATA_BITS = 8;

  // Transmitter state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // STATUS fields, packed so that full lands on bit 0 and overflow on bit 4
  typedef struct packed {
    logic ovf;
    logic irq_en;
    logic busy;
    logic empty;
    logic full;
  } status_t;

  // Zero-extend the STATUS fields to a bus word
  function automatic logic [31:0] pack_status(input status_t s);
    return {27'd0, s};
  endfunction

endpackage

// File: rtl/uart_tx_bridge_fifo.sv
// Transmit byte FIFO. Power-of-two depth, pointers carry one extra wrap
// bit to tell full from empty. The head entry is presented on dout without
// a read cycle so the transmitter can load it on the same edge it pops.
// A simultaneous push and pop is accepted even when full: the head is read
// before the freed slot is overwritten.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_rd_en;
  logic             w_wr_en;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | w_rd_en);
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// UART transmit bridge: CPU register interface (TXDATA/STATUS/DIVISOR),
// a byte FIFO and an 8N1 serialiser with a programmable bit period.
module uart_tx_bridge
  import uart_tx_bridge_pkg::*;
#(
  parameter int unsigned DIV_RESET  = 2604,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam logic [15:0] DIV_RESET_W = DIV_RESET[15:0];

  // Transmitter state
  tx_state_e   r_state;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_baud_cnt;
  logic [15:0] r_div_lat;
  logic [7:0]  r_shift;
  logic        r_txd;

  // Register file state
  logic [15:0] r_divisor;
  logic        r_irq_en;
  logic        r_ovf;
  logic        r_irq;

  // FIFO interface
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_fifo_dout;
  logic        w_fifo_full;
  logic        w_fifo_empty;

  // Derived control
  logic        w_baud_done;
  logic        w_load_frame;
  logic        w_busy;
  logic        w_drop;
  status_t     w_status;
  logic        w_unused;

  // Only the low half-word of the bus carries meaningful data
  assign w_unused = ^wdata[31:16];

  assign w_push      = we && (addr == ADDR_TXDATA);
  assign w_baud_done = (r_baud_cnt == (r_div_lat - 16'd1));

  // A new frame is loaded either from idle, or seamlessly at the very last
  // stop-bit cycle so consecutive frames have no gap between them.
  assign w_load_frame = (r_state == ST_IDLE) ||
                        ((r_state == ST_STOP) && w_baud_done);
  assign w_pop        = w_load_frame && !w_fifo_empty;

  assign w_busy = (r_state != ST_IDLE) || !w_fifo_empty;

  // A byte is lost only when the FIFO is full and nothing leaves this cycle
  assign w_drop = w_push && w_fifo_full && !w_pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (wdata[7:0]),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Serialiser FSM: start bit, 8 data bits LSB first, stop bit; each bit
  // held for r_div_lat cycles. The divisor is sampled only at frame load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= 16'd0;
      r_div_lat  <= DIV_RESET_W;
      r_shift    <= 8'd0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state    <= ST_START;
            r_shift    <= w_fifo_dout;
            r_div_lat  <= r_divisor;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_txd      <= 1'b0;
          end
        end

        ST_START: begin
          if (w_baud_done) begin
            r_state    <= ST_DATA;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_txd      <= r_shift[0];
            r_shift    <= r_shift >> 1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        ST_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        ST_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            if (w_pop) begin
              r_state   <= ST_START;
              r_shift   <= w_fifo_dout;
              r_div_lat <= r_divisor;
              r_txd     <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Writable registers and the sticky overflow flag; a fresh overflow
  // beats a clearing STATUS read in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_divisor <= DIV_RESET_W;
      r_irq_en  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (we && (addr == ADDR_DIVISOR) && (wdata[15:0] != 16'd0)) begin
        r_divisor <= wdata[15:0];
      end
      if (we && (addr == ADDR_STATUS)) begin
        r_irq_en <= wdata[STAT_IRQ_EN];
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (re && (addr == ADDR_STATUS)) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Level interrupt: transmitter fully drained and interrupts enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en && !w_busy;
    end
  end

  assign w_status.ovf    = r_ovf;
  assign w_status.irq_en = r_irq_en;
  assign w_status.busy   = w_busy;
  assign w_status.empty  = w_fifo_empty;
  assign w_status.full   = w_fifo_full;

  // Combinational read mux; TXDATA and the reserved slot read as zero
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_STATUS:  rdata = pack_status(w_status);
      ADDR_DIVISOR: rdata = {16'd0, r_divisor};
      default:      rdata = 32'd0;
    endcase
  end

  assign txd = r_txd;
  assign irq = r_irq;

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Self-checking bench for uart_tx_bridge: directed scenarios with literal
// expectations, then randomized bus traffic compared every cycle against a
// frame-timing model (queue of bytes + start time of the current frame).
module tb_uart_tx_bridge;

  localparam int DEPTH   = 8;
  localparam int DIV_RST = 2604;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int n_vec;
  int n_miss;

  uart_tx_bridge #(
    .DIV_RESET  (DIV_RST),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         cyc;
  bit         chk_en;
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_t0;
  int         m_fdiv;
  logic [7:0] m_byte;
  int         m_div;
  bit         m_irq_en;
  bit         m_ovf;
  bit         m_irq;
  bit         m_txd;
  bit         pre_busy;
  bit         pre_irq_en;
  bit         ovf_set;
  int         idx;

  initial begin
    cyc = 0; chk_en = 0; m_active = 0; m_t0 = 0; m_fdiv = 1; m_byte = 0;
    m_div = DIV_RST; m_irq_en = 0; m_ovf = 0; m_irq = 0; m_txd = 1;
  end

  // Each frame occupies 10*divisor cycles from the edge it was loaded on;
  // the line value is simply frame bit floor(elapsed/divisor).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_q.delete();
      m_active = 0; m_div = DIV_RST; m_irq_en = 0; m_ovf = 0; m_irq = 0;
      chk_en = 1;
    end else begin
      pre_busy   = m_active || (m_q.size() != 0);
      pre_irq_en = m_irq_en;
      ovf_set    = 0;
      if (m_active && (cyc - m_t0 == 10 * m_fdiv)) m_active = 0;
      if (!m_active && m_q.size() != 0) begin
        m_byte   = m_q.pop_front();
        m_t0     = cyc;
        m_fdiv   = m_div;
        m_active = 1;
      end
      if (we) begin
        case (addr)
          2'd0: if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]); else ovf_set = 1;
          2'd1: m_irq_en = wdata[3];
          2'd2: if (wdata[15:0] != 16'd0) m_div = int'(wdata[15:0]);
          default: ;
        endcase
      end
      if (re && addr == 2'd1) m_ovf = 0;
      if (ovf_set) m_ovf = 1;
      m_irq = pre_irq_en && !pre_busy;
    end
    if (m_active) begin
      idx = (cyc - m_t0) / m_fdiv;
      if (idx == 0)      m_txd = 0;
      else if (idx >= 9) m_txd = 1;
      else               m_txd = m_byte[idx-1];
    end else begin
      m_txd = 1;
    end
  end

  // Compare process: every cycle, away from the active edge
  logic [31:0] exp_rd;
  bit          e_busy;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = m_active || (m_q.size() != 0);
      case (addr)
        2'd1: exp_rd = {27'd0, m_ovf, m_irq_en, e_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
        2'd2: exp_rd = 32'(m_div);
        default: exp_rd = 32'd0;
      endcase
      n_vec = n_vec + 1;
      if (txd !== m_txd) begin
        n_miss = n_miss + 1;
        $display("FAIL txd cyc=%0d got %b expected %b", cyc, txd, m_txd);
      end
      n_vec = n_vec + 1;
      if (irq !== m_irq) begin
        n_miss = n_miss + 1;
        $display("FAIL irq cyc=%0d got %b expected %b", cyc, irq, m_irq);
      end
      n_vec = n_vec + 1;
      if (rdata !== exp_rd) begin
        n_miss = n_miss + 1;
        $display("FAIL rdata cyc=%0d addr=%0d got 0x%08h expected 0x%08h", cyc, addr, rdata, exp_rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    $display("[%0d] WR addr=%0d data=0x%08h", cyc, a, d);
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input bit clr, output logic [31:0] d);
    addr = a; re = clr;
    @(negedge clk);
    d = rdata;
    $display("[%0d] RD addr=%0d re=%0d data=0x%08h", cyc, a, clr, d);
    cycle();
    re = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    $display("[%0d] RESET", cyc);
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d;
  logic [9:0]  pat;
  int          r;

  initial begin
    n_vec = 0; n_miss = 0;
    reset = 1'b1; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 32'd0;
    repeat (3) cycle();
    reset = 1'b0;

    // Reset state
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, 1'b0, d); chk("rst_status", d, 32'h2);
    rd(2'd2, 1'b0, d); chk("rst_divisor", d, 32'd2604);

    // 0x55 at 4 cycles/bit: start, 1,0,1,0,1,0,1,0, stop
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h55);
    chk("f55_pre", {31'd0, txd}, 32'd1);
    pat = 10'b1010101010;
    for (int j = 0; j < 40; j++) begin
      cycle();
      chk($sformatf("f55_bit%0d", j), {31'd0, txd}, {31'd0, pat[j/4]});
    end
    rd(2'd1, 1'b0, d); chk("f55_busy_last", d, 32'h6);
    rd(2'd1, 1'b0, d); chk("f55_busy_done", d, 32'h2);

    // Burst of 10 writes: ninth entry fills the FIFO, tenth is dropped
    for (int k = 0; k < 10; k++) wr(2'd0, 32'(k));
    rd(2'd1, 1'b1, d); chk("ovf_read1", d, 32'h15);
    rd(2'd1, 1'b1, d); chk("ovf_read2", d, 32'h05);
    repeat (9 * 40 + 10) cycle();

    // Divisor change mid-frame affects only the next frame
    wr(2'd0, 32'hA3);
    repeat (9) cycle();
    wr(2'd2, 32'd8);
    wr(2'd0, 32'h3C);
    repeat (2) cycle();
    chk("a3_rel12", {31'd0, txd}, 32'd0);
    repeat (40) cycle();
    chk("3c_rel12", {31'd0, txd}, 32'd0);
    repeat (12) cycle();
    chk("3c_rel24", {31'd0, txd}, 32'd1);
    repeat (60) cycle();
    rd(2'd2, 1'b0, d); chk("div8", d, 32'd8);

    // Interrupt on drain
    wr(2'd2, 32'd2);
    wr(2'd1, 32'h8);
    wr(2'd0, 32'hFF);
    repeat (20) cycle();
    chk("irq_t20", {31'd0, irq}, 32'd0);
    cycle();
    chk("irq_t21", {31'd0, irq}, 32'd0);
    cycle();
    chk("irq_t22", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'h0);
    chk("irq_dis0", {31'd0, irq}, 32'd1);
    cycle();
    chk("irq_dis1", {31'd0, irq}, 32'd0);

    // Reset in data bit 3 of 0x0F aborts the frame
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h0F);
    repeat (17) cycle();
    chk("r31_bit3", {31'd0, txd}, 32'd1);
    pulse_reset();
    chk("r31_txd", {31'd0, txd}, 32'd1);
    rd(2'd1, 1'b0, d); chk("r31_status", d, 32'h2);
    rd(2'd2, 1'b0, d); chk("r31_div", d, 32'd2604);
    repeat (40) cycle();

    // Ignored divisor write, zero-reading offsets
    wr(2'd2, 32'd0);
    rd(2'd2, 1'b0, d); chk("div0_ignored", d, 32'd2604);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 1'b1, d); chk("rsvd_zero", d, 32'd0);
    rd(2'd0, 1'b0, d); chk("txdata_zero", d, 32'd0);

    // Randomized traffic
    wr(2'd2, 32'($urandom_range(1, 5)));
    for (int it = 0; it < 2000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        wr(2'd0, 32'($urandom_range(0, 255)));
      end else if (r < 48) begin
        wr(2'd2, {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 5))});
      end else if (r < 60) begin
        rd(2'd1, 1'($urandom_range(0, 1)), d);
      end else if (r < 66) begin
        wr(2'd1, $urandom);
      end else if (r < 72) begin
        rd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
      end else if (r < 73) begin
        pulse_reset();
        wr(2'd2, 32'($urandom_range(1, 5)));
      end else begin
        repeat ($urandom_range(1, 40)) cycle();
      end
    end
    repeat (600) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
